// File: rtl/residual_recon.sv
// residual_recon: reconstruction stage. Adds a row of eight signed 9-bit
// residuals to an 8-pixel prediction row, clips each pixel to 0..255 and
// emits the 64-bit reconstructed row through a 2-stage valid/ready pipeline.
// The row position within a ROWS-row block and the number of clipped pixels
// in the current block travel with each output row.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ena             global enable, low freezes every register
//   in_valid/ready  input handshake for PRED (8 x u8) and RES (8 x s9)
//   out_valid/ready output handshake for REC (8 x u8)
//   row_idx         row number of REC within its block
//   block_last      REC is the final row of its block
//   clip_cnt        clipped pixels in the block so far, including REC

// One pixel lane: stage-1 widening add and stage-2 clamp.
module residual_recon_lane (
    input  logic [7:0] pred,
    input  logic [8:0] res,
    output logic [9:0] sum,
    input  logic [9:0] s1_sum,
    output logic [7:0] pix,
    output logic       clip
);
    // Range -256..510 fits 10-bit signed; bit 9 is the sign.
    assign sum = {2'b00, pred} + {res[8], res};

    // Non-negative sums never reach 512, so bit 8 alone flags > 255.
    always_comb begin
        pix  = s1_sum[7:0];
        clip = 1'b0;
        if (s1_sum[9]) begin
            pix  = 8'h00;
            clip = 1'b1;
        end else if (s1_sum[8]) begin
            pix  = 8'hFF;
            clip = 1'b1;
        end
    end
endmodule

module residual_recon #(
    parameter int ROWS   = 8,
    parameter int ROW_W  = 3,
    parameter int CLIP_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       PRED,
    input  logic [71:0]       RES,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       REC,
    output logic [ROW_W-1:0]  row_idx,
    output logic              block_last,
    output logic [CLIP_W-1:0] clip_cnt
);
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 8;
    localparam int RES_W     = 9;
    localparam int SUM_W     = 10;

    logic [NUM_LANES-1:0][VEC_W-1:0] pred_v, pix_c;
    logic [NUM_LANES-1:0][RES_W-1:0] res_v;
    logic [NUM_LANES-1:0][SUM_W-1:0] sum_c, s1_sum;
    logic [NUM_LANES-1:0]            clip_c;
    logic [2:1]                      vld_pipe;

    logic              advance, hs;
    logic [ROW_W-1:0]  idx_next, load_idx;
    logic [CLIP_W-1:0] row_clips, clip_base;

    assign pred_v = PRED;
    assign res_v  = RES;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        residual_recon_lane u_lane (
            .pred   (pred_v[k]),
            .res    (res_v[k]),
            .sum    (sum_c[k]),
            .s1_sum (s1_sum[k]),
            .pix    (pix_c[k]),
            .clip   (clip_c[k])
        );
    end

    // Both stages move together; a stalled output freezes the whole pipe.
    assign advance    = ena && rst && (!vld_pipe[2] || out_ready);
    assign in_ready   = advance;
    assign out_valid  = vld_pipe[2];
    assign hs         = advance && vld_pipe[2];
    assign block_last = (row_idx == ROW_W'(ROWS - 1));
    assign idx_next   = block_last ? '0 : row_idx + ROW_W'(1);

    // Index the incoming row will carry: row_idx moves on this edge only if
    // the current row is handed off now.
    assign load_idx  = hs ? idx_next : row_idx;
    assign clip_base = (load_idx == '0) ? '0 : clip_cnt;

    always_comb begin
        row_clips = '0;
        for (int i = 0; i < NUM_LANES; i++)
            row_clips = row_clips + CLIP_W'(clip_c[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
            s1_sum   <= '0;
            REC      <= '0;
            row_idx  <= '0;
            clip_cnt <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid;
            vld_pipe[2] <= vld_pipe[1];
            if (in_valid)
                s1_sum <= sum_c;
            if (hs)
                row_idx <= idx_next;
            if (vld_pipe[1]) begin
                REC      <= pix_c;
                clip_cnt <= clip_base + row_clips;
            end
        end
    end
endmodule

// File: tb/tb_residual_recon.sv
module tb_residual_recon;
    typedef struct {
        logic [63:0] pred;
        logic [71:0] res;
        logic [63:0] rec;
        logic [2:0]  idx;
        logic [6:0]  clip;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, ena, in_valid, in_ready, out_valid, out_ready, block_last;
    logic [63:0] pred, rec;
    logic [71:0] res;
    logic [2:0]  row_idx;
    logic [6:0]  clip_cnt;

    int   total = 0;
    int   bad   = 0;
    int   nout  = 0;
    int   scyc  = 0;
    int   stall_lo = 1000000;
    int   stall_hi = 1000000;
    bit   took;
    vec_t drv;
    vec_t q[$];
    vec_t tbl[10];

    residual_recon dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .PRED       (pred),
        .RES        (res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .REC        (rec),
        .row_idx    (row_idx),
        .block_last (block_last),
        .clip_cnt   (clip_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] p, input logic [8:0] r,
                                input logic [7:0] o, input logic [2:0] idx,
                                input logic [6:0] c);
        vec_t v;
        v.pred = {8{p}};
        v.res  = {8{r}};
        v.rec  = {8{o}};
        v.idx  = idx;
        v.clip = c;
        return v;
    endfunction

    // PRED=CUR, RES=ORG-CUR, so the reconstruction must equal ORG.
    function automatic vec_t mk_rand(input int i);
        vec_t v;
        for (int k = 0; k < 8; k++) begin
            int org, cur;
            org = int'($urandom_range(0, 255));
            cur = int'($urandom_range(0, 255));
            v.pred[8*k +: 8] = 8'(cur);
            v.res[9*k +: 9]  = 9'(org - cur);
            v.rec[8*k +: 8]  = 8'(org);
        end
        v.idx  = 3'(i % 8);
        v.clip = 7'd0;
        return v;
    endfunction

    task automatic check_out();
        vec_t e;
        if (q.size() == 0) begin
            chk("extra_row", 72'd1, 72'd0);
        end else begin
            e = q.pop_front();
            chk("rec", 72'(rec), 72'(e.rec));
            chk("row_idx", 72'(row_idx), 72'(e.idx));
            chk("block_last", 72'(block_last), 72'(e.idx == 3'd7));
            chk("clip_cnt", 72'(clip_cnt), 72'(e.clip));
        end
        nout++;
    endtask

    // Called at posedge+1; inputs already set by the caller.
    task automatic tick();
        out_ready = !(scyc >= stall_lo && scyc <= stall_hi);
        #1;
        if (out_valid && out_ready && ena && rst) check_out();
        if (!out_ready && out_valid) chk("stall_in_ready", 72'(in_ready), 72'd0);
        if (in_valid && in_ready) begin
            q.push_back(drv);
            took = 1'b1;
        end
        @(posedge clk);
        #1;
        scyc++;
    endtask

    task automatic send(input vec_t v);
        drv      = v;
        pred     = v.pred;
        res      = v.res;
        in_valid = 1'b1;
        took     = 1'b0;
        for (int n = 0; n < 100 && !took; n++) tick();
        if (!took) chk("accept_timeout", 72'd0, 72'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        chk("drain_empty", 72'(q.size()), 72'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        q.delete();
        nout = 0;
        scyc = 0;
    endtask

    initial begin
        tbl[0] = mk(8'h80, 9'h00A, 8'h8A, 3'd0, 7'd0);
        tbl[1] = mk(8'hFF, 9'h001, 8'hFF, 3'd1, 7'd8);
        tbl[2] = mk(8'h00, 9'h100, 8'h00, 3'd2, 7'd16);
        tbl[3] = mk(8'hFF, 9'h000, 8'hFF, 3'd3, 7'd16);
        tbl[4] = mk(8'h00, 9'h000, 8'h00, 3'd4, 7'd16);
        tbl[5] = mk(8'h01, 9'h1FF, 8'h00, 3'd5, 7'd16);
        // Mixed row: exact 255 and 0 without clamping, plus 5 clamped lanes.
        tbl[6].pred = 64'h00_10_20_F0_FE_05_80_7F;
        tbl[6].res  = {9'h100, 9'h0FF, 9'h1DF, 9'h00F, 9'h002, 9'h1FB, 9'h17F, 9'h080};
        tbl[6].rec  = 64'h00_FF_00_FF_FF_00_00_FF;
        tbl[6].idx  = 3'd6;
        tbl[6].clip = 7'd21;
        tbl[7] = mk(8'h10, 9'h0FF, 8'hFF, 3'd7, 7'd29);
        tbl[8] = mk(8'hFF, 9'h001, 8'hFF, 3'd0, 7'd8);
        tbl[9] = mk(8'h40, 9'h1C0, 8'h00, 3'd1, 7'd8);

        rst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pred = '0; res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_in_ready", 72'(in_ready), 72'd0);
        chk("rst_rec", 72'(rec), 72'd0);
        chk("rst_row_idx", 72'(row_idx), 72'd0);
        chk("rst_block_last", 72'(block_last), 72'd0);
        chk("rst_clip_cnt", 72'(clip_cnt), 72'd0);
        do_reset();

        // Latency: visible exactly two cycles after acceptance.
        send(tbl[0]);
        chk("lat_cyc1_valid", 72'(out_valid), 72'd0);
        tick();
        chk("lat_cyc2_valid", 72'(out_valid), 72'd1);
        chk("lat_rec", 72'(rec), 72'(64'h8A8A8A8A8A8A8A8A));
        drain();

        // Table stream: one full block plus two rows of the next.
        do_reset();
        for (int i = 0; i < 10; i++) send(tbl[i]);
        drain();
        chk("tbl_count", 72'(nout), 72'd10);

        // ORG/CUR round trip.
        do_reset();
        for (int i = 0; i < 1000; i++) send(mk_rand(i));
        drain();
        chk("rand_count", 72'(nout), 72'd1000);

        // Stall window while streaming 16 rows.
        do_reset();
        stall_lo = 3; stall_hi = 7;
        for (int i = 0; i < 16; i++) send(mk_rand(i));
        drain();
        stall_lo = 1000000; stall_hi = 1000000;
        chk("stall_count", 72'(nout), 72'd16);

        // Reset after row 3 is accepted discards the in-flight rows.
        do_reset();
        for (int i = 0; i < 4; i++) send(tbl[i]);
        chk("pre_rst_outputs", 72'(nout), 72'd2);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 72'(in_ready), 72'd0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 72'(out_valid), 72'd0);
        chk("midrst_row_idx", 72'(row_idx), 72'd0);
        chk("midrst_clip_cnt", 72'(clip_cnt), 72'd0);
        rst = 1'b1;
        q.delete();
        nout = 0;
        send(tbl[8]);
        drain();
        chk("post_rst_count", 72'(nout), 72'd1);

        // Enable low for 4 cycles mid-stream with out_ready toggling.
        do_reset();
        begin
            logic        s_v;
            logic [63:0] s_rec;
            logic [2:0]  s_idx;
            logic [6:0]  s_clip;
            for (int i = 0; i < 5; i++) send(mk_rand(i));
            ena = 1'b0;
            #1;
            s_v = out_valid; s_rec = rec; s_idx = row_idx; s_clip = clip_cnt;
            chk("frz_has_data", 72'(s_v), 72'd1);
            for (int j = 0; j < 4; j++) begin
                out_ready = (j % 2 == 0);
                #1;
                chk("frz_in_ready", 72'(in_ready), 72'd0);
                @(posedge clk);
                #1;
                chk("frz_out_valid", 72'(out_valid), 72'(s_v));
                chk("frz_rec", 72'(rec), 72'(s_rec));
                chk("frz_row_idx", 72'(row_idx), 72'(s_idx));
                chk("frz_clip_cnt", 72'(clip_cnt), 72'(s_clip));
            end
            ena = 1'b1;
            for (int i = 5; i < 12; i++) send(mk_rand(i));
            drain();
            chk("ena_count", 72'(nout), 72'd12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
